// File: rtl/pito_pkg.sv
// Shared types and default sizing for the pito hart scheduler slice.
// Latency: n/a (types only).
// Backpressure: n/a.
package pito_pkg;

   localparam int DEF_NUM_HARTS = 8;
   localparam int DEF_HART_W    = $clog2(DEF_NUM_HARTS);

   // Per-hart lifecycle state; encodings are visible to debug tooling.
   typedef enum logic [1:0] {
      HALTED  = 2'd0,
      PENDING = 2'd1,
      RUNNING = 2'd2,
      WAITING = 2'd3
   } hart_state_t;

   typedef enum logic [1:0] {
      CMD_NOP    = 2'd0,
      CMD_START  = 2'd1,
      CMD_HALT   = 2'd2,
      CMD_RESUME = 2'd3
   } sched_cmd_e;

endpackage

// File: rtl/pito_rr_pick.sv
// Round-robin first-set finder: first set bit of eligible, scanning from ptr+1 with wrap.
// Latency: combinational.
// Backpressure: none.
// Ports: eligible (N-bit mask), ptr (last served index), found, idx (selected index).
module pito_rr_pick #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] eligible,
   input  logic [W-1:0] ptr,
   output logic         found,
   output logic [W-1:0] idx
);

   logic [W-1:0] cand;

   // N is a power of two, so W-bit addition wraps modulo N for free; the
   // last iteration (i == N) revisits ptr itself.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int i = 1; i <= N; i++) begin
         cand = ptr + W'(i);
         if (!found && eligible[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/pito_hart_scheduler.sv
// Per-hart lifecycle FSMs plus round-robin issue slot for the barrel core.
// Latency: one cycle from registered hart state to issue slot; cmd_err one cycle after the command.
// Backpressure: slot holds while issue_ready=0, unless its hart is halted or starts waiting (slot cancelled).
// Ports: cmd_* host/debug commands, wait_*/wake_mask pipeline events,
//        issue_* fetch slot (valid/ready), running_mask/all_halted state decodes.
module pito_hart_scheduler
   import pito_pkg::*;
#(
   parameter int                   NUM_HARTS = DEF_NUM_HARTS,
   parameter int                   HART_W    = $clog2(NUM_HARTS),
   parameter logic [31:0]          RESET_PC  = 32'h0000_0000,
   parameter logic [NUM_HARTS-1:0] BOOT_MASK = NUM_HARTS'(1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   input  logic [1:0]           cmd_op,
   input  logic [HART_W-1:0]    cmd_hart,
   input  logic [31:0]          cmd_pc,
   output logic                 cmd_err,
   input  logic                 wait_valid,
   input  logic [HART_W-1:0]    wait_hart,
   input  logic [NUM_HARTS-1:0] wake_mask,
   output logic                 issue_valid,
   input  logic                 issue_ready,
   output logic [HART_W-1:0]    issue_hart,
   output logic                 issue_pc_load,
   output logic [31:0]          issue_pc,
   output logic [NUM_HARTS-1:0] running_mask,
   output logic                 all_halted
);

   hart_state_t          st_q [NUM_HARTS];
   hart_state_t          st_d [NUM_HARTS];
   logic [31:0]          pc_q [NUM_HARTS];
   logic [31:0]          pc_d [NUM_HARTS];
   logic [NUM_HARTS-1:0] elig;
   logic [NUM_HARTS-1:0] pend;
   logic [NUM_HARTS-1:0] halted;
   logic [HART_W-1:0]    rr_ptr;
   logic [HART_W-1:0]    pick_ptr;
   logic [HART_W-1:0]    pick_idx;
   logic                 pick_found;
   logic                 hs;
   logic                 promote;
   logic                 cancel;
   logic                 cmd_err_d;
   sched_cmd_e           op;

   assign op      = sched_cmd_e'(cmd_op);
   assign hs      = issue_valid & issue_ready;
   assign promote = hs & issue_pc_load;

   // Next-state per hart. Later assignments override earlier ones, which
   // encodes the priority HALT > START/RESUME > wait > wake. A wake bit in
   // the same cycle as wait_valid cancels the wait.
   always_comb begin
      for (int h = 0; h < NUM_HARTS; h++) begin
         st_d[h] = st_q[h];
         pc_d[h] = pc_q[h];
         if (promote && issue_hart == HART_W'(h) && st_q[h] == PENDING)
            st_d[h] = RUNNING;
         if (st_q[h] == WAITING && wake_mask[h])
            st_d[h] = RUNNING;
         if (st_q[h] == RUNNING && wait_valid && wait_hart == HART_W'(h) && !wake_mask[h])
            st_d[h] = WAITING;
         if (cmd_valid && cmd_hart == HART_W'(h)) begin
            case (op)
               CMD_START:  if (st_q[h] == HALTED) begin
                              st_d[h] = PENDING;
                              pc_d[h] = cmd_pc;
                           end
               CMD_HALT:   if (st_q[h] != HALTED)  st_d[h] = HALTED;
               CMD_RESUME: if (st_q[h] == WAITING) st_d[h] = RUNNING;
               default:    ;
            endcase
         end
      end
   end

   always_comb begin
      cmd_err_d = 1'b0;
      if (cmd_valid) begin
         case (op)
            CMD_START:  cmd_err_d = (st_q[cmd_hart] != HALTED);
            CMD_HALT:   cmd_err_d = (st_q[cmd_hart] == HALTED);
            CMD_RESUME: cmd_err_d = (st_q[cmd_hart] != WAITING);
            default:    cmd_err_d = 1'b0;
         endcase
      end
   end

   // A hart whose PC-load slot is being accepted this edge is still PENDING
   // in the registers; mask it so a back-to-back reissue does not reload.
   always_comb begin
      for (int h = 0; h < NUM_HARTS; h++) begin
         elig[h]   = (st_q[h] == PENDING) || (st_q[h] == RUNNING);
         pend[h]   = (st_q[h] == PENDING) && !(promote && issue_hart == HART_W'(h));
         halted[h] = (st_q[h] == HALTED);
      end
   end

   assign running_mask = elig;
   assign all_halted   = &halted;

   assign pick_ptr = hs ? issue_hart : rr_ptr;
   // Held slot is dropped as soon as its hart is halted or goes to wait.
   assign cancel   = issue_valid && !issue_ready &&
                     (st_d[issue_hart] == HALTED || st_d[issue_hart] == WAITING);

   pito_rr_pick #(.N(NUM_HARTS), .W(HART_W)) u_pick (
      .eligible (elig),
      .ptr      (pick_ptr),
      .found    (pick_found),
      .idx      (pick_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int h = 0; h < NUM_HARTS; h++) begin
            st_q[h] <= BOOT_MASK[h] ? PENDING : HALTED;
            pc_q[h] <= BOOT_MASK[h] ? RESET_PC : 32'h0;
         end
         rr_ptr        <= HART_W'(NUM_HARTS - 1);
         cmd_err       <= 1'b0;
         issue_valid   <= 1'b0;
         issue_hart    <= '0;
         issue_pc_load <= 1'b0;
         issue_pc      <= 32'h0;
      end else begin
         for (int h = 0; h < NUM_HARTS; h++) begin
            st_q[h] <= st_d[h];
            pc_q[h] <= pc_d[h];
         end
         cmd_err <= cmd_err_d;
         if (hs)
            rr_ptr <= issue_hart;
         if (cancel) begin
            issue_valid   <= 1'b0;
            issue_pc_load <= 1'b0;
            issue_pc      <= 32'h0;
         end else if (!issue_valid || hs) begin
            issue_valid   <= pick_found;
            issue_hart    <= pick_idx;
            issue_pc_load <= pick_found & pend[pick_idx];
            issue_pc      <= (pick_found & pend[pick_idx]) ? pc_q[pick_idx] : 32'h0;
         end
      end
   end

endmodule
